// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the single write port of a synchronous FIFO among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add saturating per-producer write and drop statistics counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic                          drop_err
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]          drop_count
`endif
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W:0]     scan_sum;
  logic [BURST_W-1:0] burst_cnt;
  logic               pick_valid;
  logic               owner_req;
  logic               transfer;
  logic               burst_done;
  logic               release_gnt;
  logic               wr_en_q;

  // Scan from rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
      if (!pick_valid && req[scan_sum[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_sum[IDX_W-1:0];
      end
    end
  end

  assign owner_req  = |(gnt & req);
  assign transfer   = owner_req & ~fifo_full;
  assign fifo_wr_en = transfer;

  // gnt is one-hot or zero, so OR-ing the masked slices acts as the data mux.
  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i])
        fifo_data_in = fifo_data_in | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign burst_done  = ((BURST_W+1)'(burst_cnt) + (BURST_W+1)'(1)) == (BURST_W+1)'(MAX_BURST);
  assign release_gnt = (state == GRANT) &
                       (~owner_req | (transfer & (burst_done | fifo_almostfull)));
  assign next_ptr    = (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && !fifo_full) begin
            state     <= GRANT;
            gnt       <= NUM_REQ'(1) << pick_idx;
            owner     <= pick_idx;
            burst_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= next_ptr;
            burst_cnt <= '0;
            busy      <= 1'b0;
          end else if (transfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The FIFO acks one cycle after wr_en; a missing ack is flagged the cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      wr_en_q  <= fifo_wr_en;
      drop_err <= wr_en_q & ~fifo_wr_ack;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fifo_wr_en && gnt[i] && (wr_count[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX))
          wr_count[i*CNT_WIDTH +: CNT_WIDTH] <= wr_count[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
      if (wr_en_q && !fifo_wr_ack && (drop_count != CNT_MAX))
        drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, a FIFO ack responder, and a
// cycle-level reference model checked every cycle, plus directed literal checks.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int MAX_BURST  = 4;
  localparam int CNT_WIDTH  = 16;

  typedef logic [15:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  gnt;
  logic        fifo_full = 1'b0;
  logic        fifo_almostfull = 1'b0;
  logic        fifo_wr_ack = 1'b0;
  logic        fifo_wr_en;
  logic [15:0] fifo_data_in;
  logic        busy;
  logic        drop_err;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] wr_count;
  logic [15:0] drop_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull), .fifo_wr_ack(fifo_wr_ack),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .busy(busy), .drop_err(drop_err)
`ifdef FIFO_WR_ARB_STATS_EN
    , .wr_count(wr_count), .drop_count(drop_count)
`endif
  );

  word_q_t pq [NUM_REQ];
  logic [3:0] taken_s = '0;
  logic       wr_s = 1'b0;
  int         wr_total = 0;
  int         withhold_idx = 0;

  int         g_idx[$];
  int         g_wr[$];
  int         g_gap[$];
  logic [15:0] rd_q[$];
  int         zero_run = 0, run = 0, max_run = 0, cyc = 0;
  int         drop_pulses = 0, drop_cyc = -1, miss_cyc = -100;
  logic [3:0] prev_gnt = '0;
  logic       prev_wr = 1'b0;

  int m_owner = -1, m_cnt = 0, m_ptr = 0;
  bit m_pend = 1'b0, m_drop = 1'b0;
  int m_wrc[NUM_REQ];
  int m_dropc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ohIdx(input logic [3:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int atI(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -99;
  endfunction

  function automatic logic [15:0] atW(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 16'hxxxx;
  endfunction

  function automatic logic expWr();
    return (m_owner >= 0) && req[m_owner] && !fifo_full;
  endfunction

  // Reference model: who owns the port, how many writes it has made, where the rotation resumes.
  always @(posedge clk) begin
    logic ew;
    ew = expWr();
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_pend = 1'b0; m_drop = 1'b0; m_dropc = 0;
      for (int i = 0; i < NUM_REQ; i++) m_wrc[i] = 0;
    end else begin
      m_drop = m_pend && !fifo_wr_ack;
      if (m_drop && m_dropc < 65535) m_dropc++;
      m_pend = ew;
      if (ew && m_wrc[m_owner] < 65535) m_wrc[m_owner]++;
      if (m_owner < 0) begin
        if (req != 4'b0 && !fifo_full)
          for (int k = 0; k < NUM_REQ; k++)
            if (m_owner < 0 && req[(m_ptr + k) % NUM_REQ]) begin
              m_owner = (m_ptr + k) % NUM_REQ;
              m_cnt = 0;
            end
      end else begin
        if (ew) m_cnt++;
        if (!req[m_owner] || (ew && (m_cnt == MAX_BURST || fifo_almostfull))) begin
          m_ptr = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("gnt", {60'b0, gnt}, (m_owner < 0) ? 64'h0 : 64'(1 << m_owner));
    checkOutput("wr_en", {63'b0, fifo_wr_en}, {63'b0, expWr()});
    checkOutput("data", {48'b0, fifo_data_in},
                (m_owner < 0) ? 64'h0 : {48'b0, req_data[m_owner*16 +: 16]});
    checkOutput("busy", {63'b0, busy}, {63'b0, m_owner >= 0});
    checkOutput("drop_err", {63'b0, drop_err}, {63'b0, m_drop});
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++)
      checkOutput("wr_count", {48'b0, wr_count[i*16 +: 16]}, 64'(m_wrc[i]));
    checkOutput("drop_count", {48'b0, drop_count}, 64'(m_dropc));
`endif
  end

  // Observer: samples producer handshakes and logs grants, writes and drops for directed checks.
  always @(negedge clk) begin
    cyc++;
    taken_s = gnt & req & {4{!fifo_full}};
    wr_s = fifo_wr_en;
    if (gnt != 4'b0 && gnt != prev_gnt) begin
      g_idx.push_back(ohIdx(gnt));
      g_wr.push_back(0);
      g_gap.push_back(zero_run);
    end
    if (gnt == 4'b0) zero_run++; else zero_run = 0;
    if (fifo_wr_en) begin
      rd_q.push_back(fifo_data_in);
      if (g_wr.size() > 0) g_wr[g_wr.size()-1]++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (prev_wr && !fifo_wr_ack) miss_cyc = cyc;
    if (drop_err) begin drop_pulses++; drop_cyc = cyc; end
    prev_wr = fifo_wr_en;
    prev_gnt = gnt;
  end

  task automatic refresh();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = pq[i].size() > 0;
      req_data[i*16 +: 16] = (pq[i].size() > 0) ? pq[i][0] : 16'h0;
    end
  endtask

  task automatic consume();
    for (int i = 0; i < NUM_REQ; i++)
      if (taken_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    if (wr_s) wr_total++;
    fifo_wr_ack = wr_s && !(withhold_idx > 0 && wr_total == withhold_idx);
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      refresh();
      @(posedge clk);
      #1;
      consume();
    end
    refresh();
  endtask

  task automatic clearLog();
    g_idx.delete(); g_wr.delete(); g_gap.delete(); rd_q.delete();
    zero_run = 0; run = 0; max_run = 0; drop_pulses = 0; drop_cyc = -1; miss_cyc = -100;
  endtask

  task automatic doReset();
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    clearLog();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("rst_gnt", {60'b0, gnt}, 64'h0);
    checkOutput("rst_busy", {63'b0, busy}, 64'h0);
    checkOutput("rst_wr_en", {63'b0, fifo_wr_en}, 64'h0);
    checkOutput("rst_drop", {63'b0, drop_err}, 64'h0);
    clearLog();

    // Single producer, three words.
    pq[2].push_back(16'hA1); pq[2].push_back(16'hA2); pq[2].push_back(16'hA3);
    applyStimulus(1);
    #1;
    checkOutput("t1_gnt_latency", {60'b0, gnt}, 64'h4);
    applyStimulus(8);
    checkOutput("t1_rd0", {48'b0, atW(rd_q, 0)}, 64'hA1);
    checkOutput("t1_rd1", {48'b0, atW(rd_q, 1)}, 64'hA2);
    checkOutput("t1_rd2", {48'b0, atW(rd_q, 2)}, 64'hA3);
    checkOutput("t1_rd_len", 64'(rd_q.size()), 64'd3);
    checkOutput("t1_run", 64'(max_run), 64'd3);
    checkOutput("t1_grants", 64'(g_idx.size()), 64'd1);
    checkOutput("t1_gnt_clear", {60'b0, gnt}, 64'h0);

    // All four requesting continuously.
    doReset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < 8; j++) pq[i].push_back(16'(16'h1000 * (i + 1) + j));
    applyStimulus(27);
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    applyStimulus(6);
    checkOutput("t2_order0", 64'(atI(g_idx, 0)), 64'd0);
    checkOutput("t2_order1", 64'(atI(g_idx, 1)), 64'd1);
    checkOutput("t2_order2", 64'(atI(g_idx, 2)), 64'd2);
    checkOutput("t2_order3", 64'(atI(g_idx, 3)), 64'd3);
    checkOutput("t2_order4", 64'(atI(g_idx, 4)), 64'd0);
    for (int i = 0; i < 4; i++) checkOutput("t2_burst", 64'(atI(g_wr, i)), 64'd4);
    for (int i = 1; i < 5; i++) checkOutput("t2_gap", 64'(atI(g_gap, i)), 64'd1);
    checkOutput("t2_first_word", {48'b0, atW(rd_q, 0)}, 64'h1000);
    checkOutput("t2_fifth_word", {48'b0, atW(rd_q, 4)}, 64'h2000);

    // FIFO full for five cycles after two writes of producer 1.
    doReset();
    for (int j = 0; j < 6; j++) pq[1].push_back(16'(16'hB0 + j));
    applyStimulus(3);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("t3_full_wr_en", {63'b0, fifo_wr_en}, 64'h0);
      checkOutput("t3_full_gnt", {60'b0, gnt}, 64'h2);
      applyStimulus(1);
    end
    fifo_full = 1'b0;
    applyStimulus(12);
    checkOutput("t3_g0", 64'(atI(g_idx, 0)), 64'd1);
    checkOutput("t3_w0", 64'(atI(g_wr, 0)), 64'd4);
    checkOutput("t3_g1", 64'(atI(g_idx, 1)), 64'd1);
    checkOutput("t3_w1", 64'(atI(g_wr, 1)), 64'd2);
    checkOutput("t3_gap", 64'(atI(g_gap, 1)), 64'd1);
    checkOutput("t3_rd5", {48'b0, atW(rd_q, 5)}, 64'hB5);

    // Almostfull: one write per grant, rotation 0 then 3.
    doReset();
    fifo_almostfull = 1'b1;
    pq[0].push_back(16'hC0); pq[0].push_back(16'hC1);
    pq[3].push_back(16'hD0); pq[3].push_back(16'hD1);
    applyStimulus(5);
    fifo_almostfull = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    applyStimulus(4);
    checkOutput("t4_g0", 64'(atI(g_idx, 0)), 64'd0);
    checkOutput("t4_w0", 64'(atI(g_wr, 0)), 64'd1);
    checkOutput("t4_g1", 64'(atI(g_idx, 1)), 64'd3);
    checkOutput("t4_w1", 64'(atI(g_wr, 1)), 64'd1);
    checkOutput("t4_rd1", {48'b0, atW(rd_q, 1)}, 64'hD0);

    // Reset mid-burst of producer 2.
    doReset();
    for (int j = 0; j < 4; j++) pq[2].push_back(16'(16'hE0 + j));
    applyStimulus(2);
    pq[0].push_back(16'hF0); pq[0].push_back(16'hF1);
    pq[1].push_back(16'hF8);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    #1;
    checkOutput("t5_gnt", {60'b0, gnt}, 64'h0);
    checkOutput("t5_wr_en", {63'b0, fifo_wr_en}, 64'h0);
    checkOutput("t5_busy", {63'b0, busy}, 64'h0);
    applyStimulus(1);
    #1;
    checkOutput("t5_next_gnt", {60'b0, gnt}, 64'h1);
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    applyStimulus(4);

    // Withheld ack on the second write.
    doReset();
    withhold_idx = wr_total + 2;
    pq[1].push_back(16'h51); pq[1].push_back(16'h52); pq[1].push_back(16'h53);
    applyStimulus(10);
    withhold_idx = 0;
    checkOutput("t6_pulses", 64'(drop_pulses), 64'd1);
    checkOutput("t6_timing", 64'(drop_cyc), 64'(miss_cyc + 1));
`ifdef FIFO_WR_ARB_STATS_EN
    checkOutput("t6_drop_count", {48'b0, drop_count}, 64'd1);
    checkOutput("t6_wr_count1", {48'b0, wr_count[31:16]}, 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
